// File: rtl/tt_um_nishit0072e_div.sv
// Sequential 8-bit by 4-bit unsigned restoring divider.
// One quotient bit per cycle, MSB first; start is a rising edge on uio_in[4].
module tt_um_nishit0072e_div (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned DVD_W = 8;
    localparam int unsigned DSR_W = 4;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             start_q;
    logic             armed;
    logic [DVD_W-1:0] dvd;
    logic [DSR_W-1:0] dsr;
    logic [DSR_W-1:0] acc;
    logic [DVD_W-1:0] qw;
    logic [CNT_W-1:0] cnt;
    logic [DVD_W-1:0] quotient;
    logic [DSR_W-1:0] remainder;
    logic             dbz;
    logic             busy;
    logic             done;

    logic             start_det;
    logic [DSR_W-1:0] divisor_in;
    logic [DSR_W:0]   shifted;
    logic [DSR_W+1:0] diff;
    logic             borrow;
    logic [DSR_W-1:0] acc_step;
    logic [DVD_W-1:0] q_step;
    logic             unused;

    assign unused     = &{1'b0, uio_in[7:6], 1'b0};
    assign divisor_in = uio_in[DSR_W-1:0];

    // armed blocks a level that is already high when reset releases
    assign start_det = ena & armed & uio_in[4] & ~start_q;

    // One restoring iteration: shift, trial-subtract, restore on borrow
    always_comb begin
        shifted  = {acc, dvd[DVD_W-1]};
        diff     = {1'b0, shifted} - {2'b00, dsr};
        borrow   = diff[DSR_W+1];
        acc_step = borrow ? shifted[DSR_W-1:0] : diff[DSR_W-1:0];
        q_step   = {qw[DVD_W-2:0], ~borrow};
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_det) begin
                    state_next = (divisor_in == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_W'(7)) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= 1'b0;
            armed     <= 1'b0;
            dvd       <= '0;
            dsr       <= '0;
            acc       <= '0;
            qw        <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (ena) begin
            start_q <= uio_in[4];
            if (!uio_in[4]) begin
                armed <= 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_det) begin
                        if (divisor_in == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                            dbz       <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            dvd  <= ui_in;
                            dsr  <= divisor_in;
                            acc  <= '0;
                            qw   <= '0;
                            cnt  <= '0;
                            dbz  <= 1'b0;
                            busy <= 1'b1;
                            done <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    dvd <= {dvd[DVD_W-2:0], 1'b0};
                    acc <= acc_step;
                    qw  <= q_step;
                    cnt <= CNT_W'(cnt + CNT_W'(1));
                    if (cnt == CNT_W'(7)) begin
                        quotient  <= q_step;
                        remainder <= acc_step;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = uio_in[5] ? {dbz, 3'b000, remainder} : quotient;
    assign uio_out = {done, busy, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

endmodule

// File: doc/tt_um_nishit0072e_div.md
TT_UM_NISHIT0072E_DIV -- requirements
Module: tt_um_nishit0072e_div

Interface
REQ-001 clk  input  1  sole clock, all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 ena  input  1  design enable: when 0, all state holds and no start is detected.
REQ-004 ui_in  input  8  dividend, unsigned.
REQ-005 uio_in  input  8  [3:0] divisor (unsigned); [4] start; [5] rsel (result view select); [7:6] ignored.
REQ-006 uo_out  output  8  rsel=0: quotient[7:0]; rsel=1: {dbz, 3'b000, remainder[3:0]}; combinational mux of registered results.
REQ-007 uio_out  output  8  [6] busy, [7] done, [5:0] constant 0.
REQ-008 uio_oe  output  8  constant 8'b1100_0000.

Function
REQ-009 The block SHALL compute unsigned ui_in / uio_in[3:0]: 8-bit quotient, 4-bit remainder, by sequential restoring division, one quotient bit per cycle, MSB first.
REQ-010 Start detection: a start SHALL be the rising edge of uio_in[4], sampled against a registered copy of uio_in[4] with ena=1; a level held high SHALL NOT retrigger.
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
REQ-012 IDLE or DONE, start detected at edge N, divisor nonzero: latch dividend and divisor, clear the partial remainder and the iteration counter, go to RUN; busy=1 and done=0 from edge N.
REQ-013 RUN: edges N+1..N+8 SHALL each perform one iteration (shift in the next dividend bit, trial-subtract a 5-bit value, set the quotient bit, restore on borrow).
REQ-014 RUN: the 3-bit counter SHALL wrap from 7 to 0 on edge N+8, when results are registered, state becomes DONE, busy=0 and done=1; latency is exactly 8 cycles.
REQ-015 Start detected while in RUN SHALL be ignored; the operation in progress completes unaltered.
REQ-016 Start detected at edge N with divisor 0: go directly to DONE at edge N with quotient=8'hFF, remainder=4'h0, dbz=1; busy never asserts.
REQ-017 Any accepted start SHALL clear dbz; dbz is set only by REQ-016.
REQ-018 In DONE, results and done SHALL hold until the next accepted start, which clears done at that edge.
REQ-019 Input changes on ui_in and uio_in[3:0] after the start edge SHALL NOT affect the current operation (operands are latched).
REQ-020 rsel SHALL affect only the uo_out view, never internal state; switching it mid-RUN is legal.
REQ-021 Results SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor, for every nonzero divisor.
REQ-022 When ena=0 during RUN, the counter and datapath SHALL freeze; on return to ena=1 the operation resumes, extending latency by the stalled cycles.

Reset
REQ-023 While rst_n=0: state IDLE; quotient, remainder, counter, dbz, busy, done and registered start all 0; uo_out=8'h00 for either rsel; uio_out=8'h00.
REQ-024 Reset asserted mid-RUN SHALL abort immediately with no partial result retained; after release the block waits in IDLE for a fresh start edge.
REQ-025 If uio_in[4] is already high when reset is released, that level SHALL NOT count as a start.

Verification
REQ-026 100 / 7: pulse start at edge N -> busy over N..N+7, done at N+8; rsel=0 gives 8'h0E; rsel=1 gives 8'h02.
REQ-027 225 / 15 -> quotient 8'h0F, remainder 0; then 255 / 1 -> quotient 8'hFF, remainder 0, dbz=0.
REQ-028 42 / 0 -> done one edge after start, busy never high, quotient 8'hFF, rsel=1 gives 8'h80; a following 42 / 5 gives quotient 8'h08, rsel=1 gives 8'h02 (dbz cleared).
REQ-029 Second start pulse and operand changes at N+3 during 200 / 9 -> ignored; result at N+8 is quotient 8'h16, remainder 2.
REQ-030 rst_n low at N+4 of 77 / 3 -> all outputs 0 asynchronously; start held high through release is not detected; a new pulse of 77 / 3 gives quotient 8'h19, remainder 2.
REQ-031 Exhaustive sweep: all 256x15 nonzero operand pairs checked against REQ-021; ena low for 3 cycles mid-RUN gives done at N+11 with a correct result.
